hv_owt_rx_ctrl: RTL

- HV-side receiver for the LV-to-HV one-wire link; decodes the frames produced by the LV OWT transmitter.
- Line format: Manchester sync head, raw 1100 sync tail, Manchester cmd/data/CRC8, raw 1100 end tail; each half-bit is HALF_CYC clocks; line idles low.
- Delivers rw/addr/data with CRC status to the HV register/ADC logic.
- Detects the LV-side abort, which holds the line low mid-frame.

---
 rtl/owt_pkg.sv | 39 +++
 rtl/crc8_serial.sv | 31 +++
 rtl/hv_owt_rx_sampler.sv | 80 ++++++++
 rtl/hv_owt_rx_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/owt_pkg.sv
// Shared constants, FSM state type and frame payload for the HV-side one-wire receiver.
package owt_pkg;

   localparam int unsigned HALF_CYC     = 12;
   localparam int unsigned SYNC_MIN_BIT = 4;
   localparam int unsigned ADDR_W       = 7;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned CRC_W        = 8;
   localparam int unsigned ABORT_HALF   = 4;

   localparam int unsigned CMD_BITS  = 1 + ADDR_W;
   localparam int unsigned MSG_BITS  = CMD_BITS + DATA_W;
   localparam int unsigned HIST_W    = 2*SYNC_MIN_BIT + 4;
   localparam int unsigned ABORT_CYC = ABORT_HALF*HALF_CYC;
   localparam int unsigned BIT_CNT_W = $clog2(MSG_BITS);

   localparam logic [3:0]        TAIL_PAT = 4'b1100;
   // Oldest symbol at the MSB: Manchester-0 head bits followed by the raw tail.
   localparam logic [HIST_W-1:0] SYNC_PAT = {{SYNC_MIN_BIT{2'b01}}, TAIL_PAT};

   localparam logic              RD_OP        = 1'b0;
   localparam logic              WR_OP        = 1'b1;
   localparam logic [ADDR_W-1:0] REQ_ADC_ADDR = ADDR_W'(16);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_CRC,
      ST_END_TAIL
   } rx_state_e;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rx_frame_t;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (x^8+x^2+x+1), MSB first, zero seed; i_new_calc restarts on the current bit.
module crc8_serial (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_new_calc,
   input  logic       i_bit_vld,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] crc_q, crc_d;
   logic [7:0] seed_c;
   logic       fb_c;

   always_comb begin
      seed_c = i_new_calc ? 8'h00 : crc_q;
      fb_c   = seed_c[7] ^ i_bit;
      crc_d  = crc_q;
      if (i_bit_vld) begin
         crc_d = {seed_c[6:0], 1'b0} ^ (fb_c ? 8'h07 : 8'h00);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) crc_q <= 8'h00;
      else          crc_q <= crc_d;
   end

   assign o_crc = crc_q;

endmodule

// File: rtl/hv_owt_rx_sampler.sv
// Line synchronizer, edge detect, half-bit sample strobe and low-timeout detect.
// OWT_RX_GLITCH_FILT_EN inserts a 3-sample majority filter after the synchronizer.
module hv_owt_rx_sampler
   import owt_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_line,
   output logic o_edge_c,
   output logic o_smp_c,
   output logic o_sym_c,
   output logic o_low_to_c
);

   localparam int unsigned PH_W = $clog2(HALF_CYC);
   localparam int unsigned LO_W = $clog2(ABORT_CYC + 1);

   logic [1:0]      sync_q, sync_d;
   logic            prev_q, prev_d;
   logic [PH_W-1:0] ph_q, ph_d;
   logic [LO_W-1:0] lo_q, lo_d;
   logic            line_c;

`ifdef OWT_RX_GLITCH_FILT_EN
   logic [1:0] flt_hist_q, flt_hist_d;
   logic       filt_q, filt_d;

   always_comb begin
      flt_hist_d = {flt_hist_q[0], sync_q[1]};
      filt_d     = (sync_q[1] & flt_hist_q[0]) | (sync_q[1] & flt_hist_q[1]) |
                   (flt_hist_q[0] & flt_hist_q[1]);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         flt_hist_q <= 2'b00;
         filt_q     <= 1'b0;
      end else begin
         flt_hist_q <= flt_hist_d;
         filt_q     <= filt_d;
      end
   end

   assign line_c = filt_q;
`else
   assign line_c = sync_q[1];
`endif

   assign o_edge_c   = line_c ^ prev_q;
   assign o_sym_c    = line_c;
   assign o_smp_c    = i_en && !o_edge_c && (ph_q == PH_W'(HALF_CYC/2 - 1));
   assign o_low_to_c = i_en && !line_c && !o_edge_c && (lo_q == LO_W'(ABORT_CYC - 1));

   // Phase restarts on every edge so sampling lands mid half-bit; low counter saturates.
   always_comb begin
      sync_d = {sync_q[0], i_line};
      prev_d = line_c;
      ph_d   = ph_q + PH_W'(1);
      lo_d   = lo_q;
      if (!i_en || o_edge_c || ph_q == PH_W'(HALF_CYC - 1)) ph_d = '0;
      if (!i_en || o_edge_c || line_c) lo_d = '0;
      else if (lo_q != LO_W'(ABORT_CYC)) lo_d = lo_q + LO_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
         ph_q   <= '0;
         lo_q   <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         ph_q   <= ph_d;
         lo_q   <= lo_d;
      end
   end

endmodule

// File: rtl/hv_owt_rx_ctrl.sv
// HV-side one-wire frame receiver: sync lock, Manchester decode, CRC check, tail/abort handling.
// Optional OWT_RX_GLITCH_FILT_EN adds a majority glitch filter inside the sampler.
module hv_owt_rx_ctrl
   import owt_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lv_hv_owt_rx,
   input  logic              i_owt_rx_en,
   output logic              o_owt_rx_vld,
   output logic              o_owt_rx_rw,
   output logic [ADDR_W-1:0] o_owt_rx_addr,
   output logic [DATA_W-1:0] o_owt_rx_data,
   output logic              o_owt_rx_crc_err,
   output logic              o_owt_rx_frm_err,
   output logic              o_owt_rx_abort,
   output logic              o_owt_rx_busy
);

   rx_state_e            st_q, st_d;
   logic [HIST_W-1:0]    hist_q, hist_d;
   logic                 half_q, half_d;
   logic                 first_q, first_d;
   logic                 pend_q, pend_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [MSG_BITS-1:0]  msg_q, msg_d;
   logic [CRC_W-1:0]     rxcrc_q, rxcrc_d;
   rx_frame_t            frame_q, frame_d;
   logic                 crc_err_q, crc_err_d;
   logic                 vld_q, vld_d, frm_q, frm_d, abort_q, abort_d, busy_q, busy_d;

   logic              edge_c, smp_c, sym_c, low_to_c;
   logic              crc_vld_c, crc_new_c, crc_bit_c, to_idle_c, tail_bit_c;
   logic [HIST_W-1:0] hist_nxt_c;
   logic [CRC_W-1:0]  crc_c;

   hv_owt_rx_sampler u_sampler (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_owt_rx_en),
      .i_line     (i_lv_hv_owt_rx),
      .o_edge_c   (edge_c),
      .o_smp_c    (smp_c),
      .o_sym_c    (sym_c),
      .o_low_to_c (low_to_c)
   );

   crc8_serial u_crc (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_new_calc (crc_new_c),
      .i_bit_vld  (crc_vld_c),
      .i_bit      (crc_bit_c),
      .o_crc      (crc_c)
   );

   always_comb begin
      st_d      = st_q;
      hist_d    = hist_q;
      half_d    = half_q;
      first_d   = first_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      msg_d     = msg_q;
      rxcrc_d   = rxcrc_q;
      frame_d   = frame_q;
      crc_err_d = crc_err_q;
      vld_d     = 1'b0;
      frm_d     = 1'b0;
      abort_d   = 1'b0;
      crc_vld_c = 1'b0;
      crc_new_c = 1'b0;
      crc_bit_c = 1'b0;
      to_idle_c = 1'b0;
      hist_nxt_c = {hist_q[HIST_W-2:0], sym_c};
      tail_bit_c = TAIL_PAT[2'(2'd3 - cnt_q[1:0])];

      if (!i_owt_rx_en) begin
         to_idle_c = 1'b1;
      end else if (st_q != ST_IDLE && low_to_c) begin
         abort_d   = 1'b1;
         to_idle_c = 1'b1;
      end else if (pend_q) begin
         // A 00 pair may be the start of an abort; it is only a violation once the line moves.
         if (edge_c) begin
            frm_d     = 1'b1;
            to_idle_c = 1'b1;
         end
      end else if (smp_c) begin
         case (st_q)
            ST_IDLE: begin
               hist_d = hist_nxt_c;
               if (hist_nxt_c == SYNC_PAT) begin
                  st_d   = ST_CMD;
                  half_d = 1'b0;
                  cnt_d  = '0;
               end
            end
            ST_END_TAIL: begin
               if (sym_c != tail_bit_c) begin
                  frm_d     = 1'b1;
                  to_idle_c = 1'b1;
               end else if (cnt_q == BIT_CNT_W'(3)) begin
                  vld_d     = 1'b1;
                  to_idle_c = 1'b1;
                  frame_d   = rx_frame_t'(msg_q);
                  crc_err_d = (crc_c != rxcrc_q);
               end else begin
                  cnt_d = cnt_q + BIT_CNT_W'(1);
               end
            end
            default: begin
               if (!half_q) begin
                  first_d = sym_c;
                  half_d  = 1'b1;
               end else if (first_q == sym_c) begin
                  half_d = 1'b0;
                  if (sym_c) begin
                     frm_d     = 1'b1;
                     to_idle_c = 1'b1;
                  end else begin
                     pend_d = 1'b1;
                  end
               end else begin
                  half_d = 1'b0;
                  cnt_d  = cnt_q + BIT_CNT_W'(1);
                  if (st_q == ST_CRC) begin
                     rxcrc_d = {rxcrc_q[CRC_W-2:0], first_q};
                  end else begin
                     msg_d     = {msg_q[MSG_BITS-2:0], first_q};
                     crc_vld_c = 1'b1;
                     crc_new_c = (st_q == ST_CMD) && (cnt_q == '0);
                     crc_bit_c = first_q;
                  end
                  if (st_q == ST_CMD && cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
                     st_d  = ST_DATA;
                     cnt_d = '0;
                  end else if (st_q == ST_DATA && cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                     st_d  = ST_CRC;
                     cnt_d = '0;
                  end else if (st_q == ST_CRC && cnt_q == BIT_CNT_W'(CRC_W - 1)) begin
                     st_d  = ST_END_TAIL;
                     cnt_d = '0;
                  end
               end
            end
         endcase
      end

      // History is wiped on every return so frame contents can never fake a relock.
      if (to_idle_c) begin
         st_d   = ST_IDLE;
         hist_d = '0;
         half_d = 1'b0;
         pend_d = 1'b0;
         cnt_d  = '0;
      end
      busy_d = (st_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q      <= ST_IDLE;
         hist_q    <= '0;
         half_q    <= 1'b0;
         first_q   <= 1'b0;
         pend_q    <= 1'b0;
         cnt_q     <= '0;
         msg_q     <= '0;
         rxcrc_q   <= '0;
         frame_q   <= '0;
         crc_err_q <= 1'b0;
         vld_q     <= 1'b0;
         frm_q     <= 1'b0;
         abort_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         st_q      <= st_d;
         hist_q    <= hist_d;
         half_q    <= half_d;
         first_q   <= first_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         msg_q     <= msg_d;
         rxcrc_q   <= rxcrc_d;
         frame_q   <= frame_d;
         crc_err_q <= crc_err_d;
         vld_q     <= vld_d;
         frm_q     <= frm_d;
         abort_q   <= abort_d;
         busy_q    <= busy_d;
      end
   end

   assign o_owt_rx_vld     = vld_q;
   assign o_owt_rx_rw      = frame_q.rw;
   assign o_owt_rx_addr    = frame_q.addr;
   assign o_owt_rx_data    = frame_q.data;
   assign o_owt_rx_crc_err = crc_err_q;
   assign o_owt_rx_frm_err = frm_q;
   assign o_owt_rx_abort   = abort_q;
   assign o_owt_rx_busy    = busy_q;

endmodule
